// File: rtl/enemy_pkg.sv
// enemy_pkg: shared formation geometry, sprite ROM constants and enemy type codes
package enemy_pkg;
  localparam int COLS = 8;
  localparam int ROWS = 3;
  localparam int CELLS = COLS * ROWS;
  localparam int SPR_W = 39;
  localparam int SPR_H = 39;
  localparam int GAP_X = 9;
  localparam int GAP_Y = 9;
  localparam int PITCH_X = SPR_W + GAP_X;
  localparam int PITCH_Y = SPR_H + GAP_Y;
  localparam int SPR_PIX = SPR_W * SPR_H;
  localparam int ADDR_W = 12;
  localparam int EXPLODE_FRAMES = 8;
  localparam logic [11:0] TRANSP = 12'h000;
  typedef enum logic [1:0] {TYPE_A = 2'd0, TYPE_B = 2'd1, TYPE_C = 2'd2} enemy_type_e;
  function automatic enemy_type_e row_type(input logic [1:0] row);
    return row == 2'd0 ? TYPE_C : row == 2'd1 ? TYPE_B : TYPE_A;
  endfunction
endpackage

// File: rtl/enemy_grid_map.sv
// enemy_grid_map: maps a pixel onto the formation grid (cell, in-cell offset) with one stage register
module enemy_grid_map
  import enemy_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [9:0] px_x,
  input  logic [9:0] px_y,
  input  logic [9:0] org_x,
  input  logic [9:0] org_y,
  output logic       in_cell_c,
  output logic [4:0] cell_c,
  output logic       s1_valid,
  output logic       s1_in_cell,
  output logic [1:0] s1_row,
  output logic [5:0] s1_dx,
  output logic [5:0] s1_dy
);
  logic signed [10:0] rel_x, rel_y;
  logic [10:0] col_w, row_w;
  logic [5:0] dx_w, dy_w;
  // relative position, cell index and offset; negative rel is rejected via its sign bit
  always_comb begin
    rel_x = $signed({1'b0, px_x}) - $signed({1'b0, org_x});
    rel_y = $signed({1'b0, px_y}) - $signed({1'b0, org_y});
    col_w = $unsigned(rel_x) / 11'(PITCH_X);
    row_w = $unsigned(rel_y) / 11'(PITCH_Y);
    dx_w = 6'($unsigned(rel_x) % 11'(PITCH_X));
    dy_w = 6'($unsigned(rel_y) % 11'(PITCH_Y));
    in_cell_c = valid && !rel_x[10] && !rel_y[10] && col_w < 11'(COLS) && row_w < 11'(ROWS)
                && dx_w < 6'(SPR_W) && dy_w < 6'(SPR_H);
    cell_c = in_cell_c ? {row_w[1:0], col_w[2:0]} : 5'd0;
  end
  // stage register
  always_ff @(posedge clk) begin
    if (rst) begin
      {s1_valid, s1_in_cell, s1_row, s1_dx, s1_dy} <= '0;
    end else begin
      s1_valid <= valid;
      s1_in_cell <= in_cell_c;
      s1_row <= row_w[1:0];
      s1_dx <= dx_w;
      s1_dy <= dy_w;
    end
  end
endmodule

// File: rtl/enemy_sprite_scheduler.sv
// enemy_sprite_scheduler: per-pixel enemy ROM scheduler with alive bitmap and kill handshake (ENEMY_EXPLODE_EN adds dying flash)
module enemy_sprite_scheduler
  import enemy_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        px_valid,
  input  logic [9:0]  px_x,
  input  logic [9:0]  px_y,
  input  logic        frame_start,
  input  logic [9:0]  origin_x,
  input  logic [9:0]  origin_y,
  input  logic        kill_valid,
  input  logic [2:0]  kill_col,
  input  logic [1:0]  kill_row,
  output logic        kill_ack,
  output logic        kill_hit,
  output logic [1:0]  rom_type,
  output logic [11:0] rom_addr,
  input  logic [11:0] rom_data,
  output logic        out_valid,
  output logic        out_hit,
  output logic [11:0] out_color,
  output logic [4:0]  alive_count,
  output logic        all_dead
);
  logic [9:0] org_x, org_y;
  logic [CELLS-1:0] alive, dying;
  logic [4:0] kidx, cell_c;
  logic kill_ok, in_cell_c;
  logic s1_valid, s1_in_cell, s1_live, s1_dying;
  logic [1:0] s1_row;
  logic [5:0] s1_dx, s1_dy;
  logic s2_valid, s2_live, s2_dying, s3_valid, s3_live, s3_dying, opaque;
  assign kidx = {kill_row, kill_col};
  assign kill_ok = kill_valid && kill_row < 2'(ROWS) && alive[kidx];
  assign alive_count = 5'($countones(alive));
  assign all_dead = alive == '0;
  assign opaque = s3_live && rom_data != TRANSP;
  enemy_grid_map u_map (
    .clk(clk), .rst(rst), .valid(px_valid), .px_x(px_x), .px_y(px_y),
    .org_x(org_x), .org_y(org_y), .in_cell_c(in_cell_c), .cell_c(cell_c),
    .s1_valid(s1_valid), .s1_in_cell(s1_in_cell), .s1_row(s1_row), .s1_dx(s1_dx), .s1_dy(s1_dy)
  );
  // origin is latched once per frame so a frame never tears
  always_ff @(posedge clk) begin
    if (rst) begin
      org_x <= '0;
      org_y <= '0;
    end else if (frame_start) begin
      org_x <= origin_x;
      org_y <= origin_y;
    end
  end
  // kill handshake: every request acked next cycle, only a live in-range cell is cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      alive <= '1;
      kill_ack <= 1'b0;
      kill_hit <= 1'b0;
    end else begin
      kill_ack <= kill_valid;
      kill_hit <= kill_ok;
      if (kill_ok) alive[kidx] <= 1'b0;
    end
  end
`ifdef ENEMY_EXPLODE_EN
  logic [3:0] boom_cnt;
  // killed cells keep drawing white until the shared frame countdown expires
  always_ff @(posedge clk) begin
    if (rst) begin
      dying <= '0;
      boom_cnt <= '0;
    end else if (kill_ok) begin
      dying[kidx] <= 1'b1;
      boom_cnt <= 4'(EXPLODE_FRAMES);
    end else if (frame_start && boom_cnt != 4'd0) begin
      boom_cnt <= boom_cnt - 4'd1;
      if (boom_cnt == 4'd1) dying <= '0;
    end
  end
`else
  assign dying = '0;
`endif
  // pixel pipeline: S1 cell state, S2 ROM request, S3 align with ROM read, S4 output
  always_ff @(posedge clk) begin
    if (rst) begin
      {s1_live, s1_dying, s2_valid, s2_live, s2_dying, s3_valid, s3_live, s3_dying} <= '0;
      rom_addr <= '0;
      rom_type <= '0;
      out_valid <= 1'b0;
      out_hit <= 1'b0;
      out_color <= '0;
    end else begin
      s1_live <= in_cell_c && (alive[cell_c] || dying[cell_c]);
      s1_dying <= in_cell_c && dying[cell_c];
      s2_valid <= s1_valid;
      s2_live <= s1_in_cell && s1_live;
      s2_dying <= s1_dying;
      if (s1_in_cell) begin
        rom_addr <= 12'(s1_dy * SPR_W + s1_dx);
        rom_type <= row_type(s1_row);
      end
      s3_valid <= s2_valid;
      s3_live <= s2_live;
      s3_dying <= s2_dying;
      out_valid <= s3_valid;
      out_hit <= opaque;
      out_color <= !opaque ? 12'h000 : s3_dying ? 12'hFFF : rom_data;
    end
  end
endmodule

// File: tb/tb_enemy_sprite_scheduler.sv
// tb_enemy_sprite_scheduler: randomized and directed checks against a geometric reference model
module tb_enemy_sprite_scheduler;
  logic clk = 1'b0;
  logic rst, px_valid, frame_start, kill_valid;
  logic [9:0] px_x, px_y, origin_x, origin_y;
  logic [2:0] kill_col;
  logic [1:0] kill_row;
  logic kill_ack, kill_hit, out_valid, out_hit, all_dead;
  logic [1:0] rom_type;
  logic [11:0] rom_addr, rom_data, out_color;
  logic [4:0] alive_count;
  int checks = 0, passes = 0;
  int m_ox, m_oy, m_cnt;
  bit m_alive [3][8];
  bit m_dying [3][8];
  bit pv [4];
  bit ph [4];
  logic [11:0] pc [4];
  bit e_ack, e_khit;

  enemy_sprite_scheduler dut (
    .clk(clk), .rst(rst), .px_valid(px_valid), .px_x(px_x), .px_y(px_y),
    .frame_start(frame_start), .origin_x(origin_x), .origin_y(origin_y),
    .kill_valid(kill_valid), .kill_col(kill_col), .kill_row(kill_row),
    .kill_ack(kill_ack), .kill_hit(kill_hit), .rom_type(rom_type), .rom_addr(rom_addr),
    .rom_data(rom_data), .out_valid(out_valid), .out_hit(out_hit), .out_color(out_color),
    .alive_count(alive_count), .all_dead(all_dead)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_fn(input logic [1:0] t, input logic [11:0] a);
    if ((int'(a) + 3 * int'(t)) % 7 == 3) return 12'h000;
    return 12'((int'(a) * 37 + int'(t) * 1000) % 4095 + 1);
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_type, rom_addr);

  function automatic void map_px(input int x, input int y, output bit inc, output int col, output int row, output int addr);
    int rx, ry;
    rx = x - m_ox;
    ry = y - m_oy;
    col = rx / 48;
    row = ry / 48;
    addr = (ry % 48) * 39 + rx % 48;
    inc = rx >= 0 && ry >= 0 && col < 8 && row < 3 && rx % 48 < 39 && ry % 48 < 39;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int r = 0; r < 3; r++) for (int k = 0; k < 8; k++) n += int'(m_alive[r][k]);
    return n;
  endfunction

  task automatic tick();
    bit inc, v, h, kh;
    int col, row, addr;
    logic [11:0] c, d;
    @(posedge clk);
    v = 0; h = 0; c = 12'h000;
    if (rst) begin
      m_ox = 0; m_oy = 0; m_cnt = 0; e_ack = 0; e_khit = 0;
      for (int r = 0; r < 3; r++) for (int k = 0; k < 8; k++) begin m_alive[r][k] = 1; m_dying[r][k] = 0; end
      for (int i = 0; i < 4; i++) begin pv[i] = 0; ph[i] = 0; pc[i] = 12'h000; end
    end else begin
      if (px_valid) begin
        v = 1;
        map_px(int'(px_x), int'(px_y), inc, col, row, addr);
        if (inc) begin
          d = rom_fn(row == 0 ? 2'd2 : row == 1 ? 2'd1 : 2'd0, 12'(addr));
          if ((m_alive[row][col] || m_dying[row][col]) && d != 12'h000) begin
            h = 1;
            c = m_dying[row][col] ? 12'hFFF : d;
          end
        end
      end
      for (int i = 3; i > 0; i--) begin pv[i] = pv[i-1]; ph[i] = ph[i-1]; pc[i] = pc[i-1]; end
      pv[0] = v; ph[0] = h; pc[0] = c;
      e_ack = kill_valid;
      kh = 0;
      if (kill_valid && kill_row < 3) if (m_alive[kill_row][kill_col]) begin kh = 1; m_alive[kill_row][kill_col] = 0; end
      e_khit = kh;
`ifdef ENEMY_EXPLODE_EN
      if (kh) begin
        m_dying[kill_row][kill_col] = 1;
        m_cnt = 8;
      end else if (frame_start && m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) for (int r = 0; r < 3; r++) for (int k = 0; k < 8; k++) m_dying[r][k] = 0;
      end
`endif
      if (frame_start) begin m_ox = int'(origin_x); m_oy = int'(origin_y); end
    end
    #1;
  endtask

  task automatic idle();
    px_valid = 0; kill_valid = 0; frame_start = 0;
  endtask

  task automatic px_pulse(input int x, input int y);
    px_valid = 1; px_x = 10'(x); px_y = 10'(y);
    tick();
    px_valid = 0;
  endtask

  task automatic kill_req(input int c, input int r);
    kill_valid = 1; kill_col = 3'(c); kill_row = 2'(r);
    tick();
    kill_valid = 0;
  endtask

  task automatic set_origin(input int x, input int y);
    frame_start = 1; origin_x = 10'(x); origin_y = 10'(y);
    tick();
    frame_start = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    tick(); tick();
    checks++; if (alive_count !== 5'd24) $display("FAIL reset_count got %0d want 24", alive_count); else passes++;
    checks++; if (all_dead !== 1'b0) $display("FAIL reset_all_dead got %b want 0", all_dead); else passes++;
    checks++; if ({out_valid, out_hit, out_color} !== 14'h0) $display("FAIL reset_out got %b/%b/%h want 0", out_valid, out_hit, out_color); else passes++;
    checks++; if ({kill_ack, kill_hit} !== 2'b00) $display("FAIL reset_kill got %b%b want 00", kill_ack, kill_hit); else passes++;
    checks++; if ({rom_type, rom_addr} !== 14'h0) $display("FAIL reset_rom got %0d/%0d want 0/0", rom_type, rom_addr); else passes++;
    rst = 0;
  endtask

  task automatic test_origin();
    logic [11:0] d;
    d = rom_fn(2'd2, 12'd0);
    set_origin(100, 50);
    px_pulse(100, 50);
    tick();
    checks++; if (rom_type !== 2'd2) $display("FAIL origin_type got %0d want 2", rom_type); else passes++;
    checks++; if (rom_addr !== 12'd0) $display("FAIL origin_addr got %0d want 0", rom_addr); else passes++;
    tick(); tick();
    checks++; if (out_valid !== 1'b1) $display("FAIL origin_valid got %b want 1", out_valid); else passes++;
    checks++; if (out_hit !== (d != 12'h000)) $display("FAIL origin_hit got %b want %b", out_hit, d != 12'h000); else passes++;
    checks++; if (out_color !== d) $display("FAIL origin_color got %h want %h", out_color, d); else passes++;
  endtask

  task automatic test_cells();
    logic [11:0] d;
    d = rom_fn(2'd1, 12'd1520);
    px_pulse(186, 136);
    tick();
    checks++; if (rom_type !== 2'd1) $display("FAIL cell11_type got %0d want 1", rom_type); else passes++;
    checks++; if (rom_addr !== 12'd1520) $display("FAIL cell11_addr got %0d want 1520", rom_addr); else passes++;
    tick(); tick();
    checks++; if ({out_valid, out_hit, out_color} !== {1'b1, d != 12'h000, d}) $display("FAIL cell11_out got %b/%b/%h want 1/%b/%h", out_valid, out_hit, out_color, d != 12'h000, d); else passes++;
    px_pulse(140, 50);
    tick(); tick(); tick();
    checks++; if ({out_valid, out_hit, out_color} !== {1'b1, 1'b0, 12'h000}) $display("FAIL gap_out got %b/%b/%h want 1/0/000", out_valid, out_hit, out_color); else passes++;
    px_pulse(99, 50);
    tick(); tick(); tick();
    checks++; if ({out_valid, out_hit} !== 2'b10) $display("FAIL left_edge got %b/%b want 1/0", out_valid, out_hit); else passes++;
    frame_start = 1; origin_x = 10'd200; origin_y = 10'd50; px_valid = 1; px_x = 10'd100; px_y = 10'd50;
    tick();
    frame_start = 0;
    tick();
    px_valid = 0;
    tick(); tick();
    checks++; if (out_hit !== (rom_fn(2'd2, 12'd0) != 12'h000)) $display("FAIL fs_old_origin got %b want %b", out_hit, rom_fn(2'd2, 12'd0) != 12'h000); else passes++;
    tick();
    checks++; if ({out_valid, out_hit} !== 2'b10) $display("FAIL fs_new_origin got %b/%b want 1/0", out_valid, out_hit); else passes++;
    set_origin(100, 50);
  endtask

  task automatic test_kill();
    kill_req(3, 0);
    checks++; if ({kill_ack, kill_hit} !== 2'b11) $display("FAIL kill_first got %b%b want 11", kill_ack, kill_hit); else passes++;
    checks++; if (alive_count !== 5'd23) $display("FAIL kill_count got %0d want 23", alive_count); else passes++;
    kill_req(3, 0);
    checks++; if ({kill_ack, kill_hit} !== 2'b10) $display("FAIL kill_repeat got %b%b want 10", kill_ack, kill_hit); else passes++;
    checks++; if (alive_count !== 5'd23) $display("FAIL kill_repeat_count got %0d want 23", alive_count); else passes++;
    kill_req(0, 3);
    checks++; if ({kill_ack, kill_hit, alive_count} !== {2'b10, 5'd23}) $display("FAIL kill_range got %b%b/%0d want 10/23", kill_ack, kill_hit, alive_count); else passes++;
    px_pulse(100 + 3 * 48 + 10, 50 + 10);
    tick(); tick(); tick();
    checks++; if ({out_valid, out_hit, out_color} !== {pv[3], ph[3], pc[3]}) $display("FAIL dead_pixel got %b/%b/%h want %b/%b/%h", out_valid, out_hit, out_color, pv[3], ph[3], pc[3]); else passes++;
`ifndef ENEMY_EXPLODE_EN
    checks++; if (out_hit !== 1'b0) $display("FAIL dead_pixel_hit got %b want 0", out_hit); else passes++;
`endif
  endtask

  task automatic test_back_to_back();
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 24; i++) begin
      kill_valid = 1; kill_row = 2'(i / 8); kill_col = 3'(i % 8);
      tick();
      checks++; if ({kill_ack, kill_hit, alive_count} !== {2'b11, 5'(23 - i)}) $display("FAIL b2b_kill%0d got %b%b/%0d want 11/%0d", i, kill_ack, kill_hit, alive_count, 23 - i); else passes++;
    end
    kill_valid = 0;
    checks++; if (all_dead !== 1'b1) $display("FAIL b2b_all_dead got %b want 1", all_dead); else passes++;
    tick();
    checks++; if (all_dead !== 1'b1) $display("FAIL b2b_all_dead_hold got %b want 1", all_dead); else passes++;
    px_valid = 1; px_x = 10'd10; px_y = 10'd10;
    tick(); tick();
    rst = 1; tick(); rst = 0;
    checks++; if ({alive_count, all_dead} !== {5'd24, 1'b0}) $display("FAIL rst_revive got %0d/%b want 24/0", alive_count, all_dead); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_flush0 got %b want 0", out_valid); else passes++;
    for (int i = 1; i < 4; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) $display("FAIL rst_flush%0d got %b want 0", i, out_valid); else passes++;
    end
    tick();
    checks++; if (out_valid !== 1'b1) $display("FAIL rst_refill got %b want 1", out_valid); else passes++;
    px_valid = 0;
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      rst = $urandom_range(0, 399) == 0;
      px_valid = $urandom_range(0, 3) != 0;
      px_x = 10'($urandom_range(60, 560));
      px_y = 10'($urandom_range(20, 250));
      kill_valid = $urandom_range(0, 15) == 0;
      kill_col = 3'($urandom);
      kill_row = 2'($urandom);
      frame_start = $urandom_range(0, 63) == 0;
      origin_x = 10'($urandom_range(60, 140));
      origin_y = 10'($urandom_range(20, 70));
      tick();
      checks++; if ({out_valid, out_hit, out_color} !== {pv[3], ph[3], pc[3]}) $display("FAIL rand_out@%0d got %b/%b/%h want %b/%b/%h", n, out_valid, out_hit, out_color, pv[3], ph[3], pc[3]); else passes++;
      checks++; if ({kill_ack, kill_hit} !== {e_ack, e_khit}) $display("FAIL rand_kill@%0d got %b%b want %b%b", n, kill_ack, kill_hit, e_ack, e_khit); else passes++;
      checks++; if (alive_count !== 5'(m_count())) $display("FAIL rand_count@%0d got %0d want %0d", n, alive_count, m_count()); else passes++;
    end
    rst = 0; idle();
    tick(); tick(); tick(); tick();
  endtask

`ifdef ENEMY_EXPLODE_EN
  task automatic test_explode();
    bit op;
    op = rom_fn(2'd2, 12'd0) != 12'h000;
    rst = 1; tick(); rst = 0;
    set_origin(100, 50);
    kill_req(0, 0);
    checks++; if ({kill_hit, alive_count} !== {1'b1, 5'd23}) $display("FAIL boom_kill got %b/%0d want 1/23", kill_hit, alive_count); else passes++;
    for (int f = 0; f < 9; f++) begin
      px_pulse(100, 50);
      tick(); tick(); tick();
      checks++; if (out_hit !== (op && f < 8)) $display("FAIL boom_hit%0d got %b want %b", f, out_hit, op && f < 8); else passes++;
      checks++; if (out_color !== ((op && f < 8) ? 12'hFFF : 12'h000)) $display("FAIL boom_color%0d got %h want %h", f, out_color, (op && f < 8) ? 12'hFFF : 12'h000); else passes++;
      set_origin(100, 50);
    end
  endtask
`endif

  initial begin
    rst = 1; idle();
    px_x = '0; px_y = '0; origin_x = '0; origin_y = '0; kill_col = '0; kill_row = '0;
    test_reset();
    test_origin();
    test_cells();
    test_kill();
    test_back_to_back();
    test_random();
`ifdef ENEMY_EXPLODE_EN
    test_explode();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
